// File: rtl/x2821_timing_pkg.sv
// Shared types and limits for the timing ring counter.
package x2821_timing_pkg;

    typedef enum logic {
        RING_WRAP = 1'b0,
        RING_STOP = 1'b1
    } ring_mode_t;

    localparam int unsigned STAGES_MAX = 32;

endpackage

// File: rtl/ring_onehot_check.sv
// Independent one-hot ring kept in lockstep with the binary count; flags any disagreement.
// Only instantiated when TIMING_RING_ONEHOT_EN is defined.
module ring_onehot_check #(
    parameter int unsigned STAGES = 6,
    parameter int unsigned CW     = $clog2(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [CW-1:0]     load_val,
    input  logic              step,
    input  logic [CW-1:0]     count,
    output logic [STAGES-1:0] onehot,
    output logic              ring_err
);

    logic [STAGES-1:0] onehot_q;
    logic              ring_err_q;
    logic [STAGES-1:0] expected;

    assign expected = STAGES'(1) << count;

    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_q   <= STAGES'(1);
            ring_err_q <= 1'b0;
        end else begin
            if (clear) begin
                onehot_q <= STAGES'(1);
            end else if (load) begin
                onehot_q <= STAGES'(1) << load_val;
            end else if (step) begin
                // Rotation is built separately from the binary path so the two can disagree.
                onehot_q <= {onehot_q[STAGES-2:0], onehot_q[STAGES-1]};
            end
            if (onehot_q != expected) begin
                ring_err_q <= 1'b1;
            end
        end
    end

    assign onehot   = onehot_q;
    assign ring_err = ring_err_q;

endmodule

// File: rtl/timing_ring.sv
// Binary position counter over STAGES ring positions with wrap or stop-at-terminal behaviour.
// Define TIMING_RING_ONEHOT_EN to add the one-hot shadow ring and its mismatch flag.
module timing_ring
    import x2821_timing_pkg::*;
#(
    parameter int unsigned STAGES = 6,
    parameter ring_mode_t  MODE   = RING_WRAP,
    localparam int unsigned CW    = $clog2(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_advance,
    input  logic              i_hold,
    input  logic              i_load,
    input  logic [CW-1:0]     i_load_val,
    output logic [CW-1:0]     o_count,
    output logic              o_terminal,
    output logic              o_carry,
`ifdef TIMING_RING_ONEHOT_EN
    output logic [STAGES-1:0] o_onehot,
    output logic              o_ring_err,
`endif
    output logic              o_load_err
);

    localparam logic [CW-1:0] LAST = CW'(STAGES - 1);

    if (STAGES < 2 || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("timing_ring: STAGES out of range");
    end

    logic [CW-1:0] count_q, count_d;
    logic          carry_q, carry_d;
    logic          load_err_q, load_err_d;
    logic          load_ok;

    assign load_ok = 32'(i_load_val) < STAGES;

    always_comb begin
        count_d    = count_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        if (i_clear) begin
            count_d = '0;
        end else if (i_load) begin
            if (load_ok) begin
                count_d = i_load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (i_advance && !i_hold) begin
            if (count_q == LAST) begin
                if (MODE == RING_WRAP) begin
                    count_d = '0;
                    carry_d = 1'b1;
                end
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign o_count    = count_q;
    assign o_terminal = (count_q == LAST);
    assign o_carry    = carry_q;
    assign o_load_err = load_err_q;

`ifdef TIMING_RING_ONEHOT_EN
    logic oh_load;
    logic oh_step;

    assign oh_load = !i_clear && i_load && load_ok;
    assign oh_step = !i_clear && !i_load && !i_hold && i_advance &&
                     !(MODE == RING_STOP && count_q == LAST);

    ring_onehot_check #(
        .STAGES (STAGES),
        .CW     (CW)
    ) u_check (
        .clk      (clk),
        .rst      (rst),
        .clear    (i_clear),
        .load     (oh_load),
        .load_val (i_load_val),
        .step     (oh_step),
        .count    (count_q),
        .onehot   (o_onehot),
        .ring_err (o_ring_err)
    );
`endif

endmodule

// File: tb/tb_timing_ring.sv
// Self-checking bench for timing_ring: wrap and stop instances driven in parallel against a model.
// With TIMING_RING_ONEHOT_EN defined, a STAGES=10 instance exercises the one-hot shadow ring.
module tb_timing_ring;
    import x2821_timing_pkg::*;

    logic       clk = 1'b0;
    logic       rst, clr, ld, hold, adv;
    logic [2:0] ld_val;

    logic [2:0] w_count, s_count;
    logic       w_term, w_carry, w_lerr;
    logic       s_term, s_carry, s_lerr;

    int n_pass  = 0;
    int n_total = 0;

    int exp_w_count, exp_s_count;
    bit exp_w_carry, exp_w_err, exp_s_carry, exp_s_err;

    always #5 clk = ~clk;

    timing_ring #(.STAGES(6), .MODE(RING_WRAP)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (clr),
        .i_advance  (adv),
        .i_hold     (hold),
        .i_load     (ld),
        .i_load_val (ld_val),
        .o_count    (w_count),
        .o_terminal (w_term),
        .o_carry    (w_carry),
`ifdef TIMING_RING_ONEHOT_EN
        .o_onehot   (),
        .o_ring_err (),
`endif
        .o_load_err (w_lerr)
    );

    timing_ring #(.STAGES(6), .MODE(RING_STOP)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (clr),
        .i_advance  (adv),
        .i_hold     (hold),
        .i_load     (ld),
        .i_load_val (ld_val),
        .o_count    (s_count),
        .o_terminal (s_term),
        .o_carry    (s_carry),
`ifdef TIMING_RING_ONEHOT_EN
        .o_onehot   (),
        .o_ring_err (),
`endif
        .o_load_err (s_lerr)
    );

`ifdef TIMING_RING_ONEHOT_EN
    logic [3:0] t_count;
    logic [9:0] t_onehot;
    logic       t_term, t_carry, t_lerr, t_rerr;

    timing_ring #(.STAGES(10), .MODE(RING_WRAP)) dut_t (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (clr),
        .i_advance  (adv),
        .i_hold     (hold),
        .i_load     (ld),
        .i_load_val ({1'b0, ld_val}),
        .o_count    (t_count),
        .o_terminal (t_term),
        .o_carry    (t_carry),
        .o_onehot   (t_onehot),
        .o_ring_err (t_rerr),
        .o_load_err (t_lerr)
    );
`endif

    // Six-position ring, stated directly from the priority rules.
    function automatic void model_step(input bit stop, inout int c, inout bit carry,
                                       inout bit err);
        carry = 1'b0;
        err   = 1'b0;
        if (rst || clr) begin
            c = 0;
        end else if (ld) begin
            if (int'(ld_val) < 6) c = int'(ld_val);
            else err = 1'b1;
        end else if (adv && !hold) begin
            if (c < 5) c = c + 1;
            else if (!stop) begin
                c     = 0;
                carry = 1'b1;
            end
        end
    endfunction

    task automatic cycle(input bit r, input bit c, input bit l, input int v, input bit h,
                         input bit a);
        rst    = r;
        clr    = c;
        ld     = l;
        ld_val = 3'(v);
        hold   = h;
        adv    = a;
        model_step(1'b0, exp_w_count, exp_w_carry, exp_w_err);
        model_step(1'b1, exp_s_count, exp_s_carry, exp_s_err);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 7, 1, 1);
        n_total++;
        if ({w_count, w_carry, w_lerr, w_term} !== 6'b0) begin
            $display("FAIL reset_wrap: got cnt=%0d c=%b e=%b t=%b want all 0",
                     w_count, w_carry, w_lerr, w_term);
        end else n_pass++;
        n_total++;
        if ({s_count, s_carry, s_lerr, s_term} !== 6'b0) begin
            $display("FAIL reset_stop: got cnt=%0d c=%b e=%b t=%b want all 0",
                     s_count, s_carry, s_lerr, s_term);
        end else n_pass++;
    endtask

    task automatic test_wrap_run();
        int seq [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 0, 0, 1);
            n_total++;
            if ({w_count, w_carry, w_term} !== {3'(seq[i]), seq[i] == 0, seq[i] == 5}) begin
                $display("FAIL wrap_run[%0d]: got cnt=%0d c=%b t=%b want cnt=%0d", i, w_count,
                         w_carry, w_term, seq[i]);
            end else n_pass++;
            n_total++;
            if ({s_count, s_carry, s_term} !== {3'(exp_s_count), 1'b0, exp_s_count == 5}) begin
                $display("FAIL stop_run[%0d]: got cnt=%0d c=%b want cnt=%0d c=0", i, s_count,
                         s_carry, exp_s_count);
            end else n_pass++;
        end
    endtask

    task automatic test_strobe();
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 0, 0, (i % 2) == 0);
            n_total++;
            if ({w_count, w_carry} !== {3'(exp_w_count), exp_w_carry}) begin
                $display("FAIL strobe[%0d]: got cnt=%0d c=%b want cnt=%0d c=%b", i, w_count,
                         w_carry, exp_w_count, exp_w_carry);
            end else n_pass++;
        end
    endtask

    task automatic test_load();
        cycle(0, 0, 1, 4, 0, 0);
        n_total++;
        if ({w_count, s_count, w_lerr, s_lerr} !== {3'd4, 3'd4, 2'b00}) begin
            $display("FAIL load4: got w=%0d s=%0d err=%b%b want 4 4 00", w_count, s_count,
                     w_lerr, s_lerr);
        end else n_pass++;
        cycle(0, 0, 1, 7, 0, 1);
        n_total++;
        if ({w_count, s_count, w_lerr, s_lerr} !== {3'd4, 3'd4, 2'b11}) begin
            $display("FAIL load7: got w=%0d s=%0d err=%b%b want 4 4 11", w_count, s_count,
                     w_lerr, s_lerr);
        end else n_pass++;
        cycle(0, 0, 0, 0, 1, 0);
        n_total++;
        if ({w_count, w_lerr, s_lerr} !== {3'd4, 2'b00}) begin
            $display("FAIL load_err_pulse: got cnt=%0d err=%b%b want 4 00", w_count, w_lerr,
                     s_lerr);
        end else n_pass++;
    endtask

    task automatic test_stop();
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 0, 0, 1);
            n_total++;
            if (s_carry !== 1'b0) begin
                $display("FAIL stop_carry[%0d]: got %b want 0", i, s_carry);
            end else n_pass++;
        end
        n_total++;
        if ({s_count, s_term} !== {3'd5, 1'b1}) begin
            $display("FAIL stop_sat: got cnt=%0d t=%b want cnt=5 t=1", s_count, s_term);
        end else n_pass++;
        cycle(0, 1, 0, 0, 0, 1);
        n_total++;
        if ({s_count, s_term, s_carry} !== 5'b0) begin
            $display("FAIL stop_clear: got cnt=%0d t=%b c=%b want 0", s_count, s_term, s_carry);
        end else n_pass++;
    endtask

    task automatic test_priority();
        cycle(1, 0, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 1);
        n_total++;
        if ({w_count, w_carry} !== 4'b0) begin
            $display("FAIL clear_adv: got cnt=%0d c=%b want 0", w_count, w_carry);
        end else n_pass++;
        cycle(0, 0, 1, 2, 1, 1);
        n_total++;
        if ({w_count, s_count} !== {3'd2, 3'd2}) begin
            $display("FAIL load_hold: got w=%0d s=%0d want 2 2", w_count, s_count);
        end else n_pass++;
        cycle(0, 0, 0, 0, 1, 1);
        n_total++;
        if (w_count !== 3'd2) begin
            $display("FAIL hold_adv: got %0d want 2", w_count);
        end else n_pass++;
        cycle(0, 0, 1, 5, 0, 0);
        cycle(0, 1, 1, 7, 0, 1);
        n_total++;
        if ({w_count, w_carry, w_lerr} !== 5'b0) begin
            $display("FAIL clear_over_badload: got cnt=%0d c=%b e=%b want 0", w_count,
                     w_carry, w_lerr);
        end else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 3, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 7) == 0, int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
            n_total++;
            if ({w_count, w_carry, w_lerr, w_term} !==
                {3'(exp_w_count), exp_w_carry, exp_w_err, exp_w_count == 5}) begin
                $display("FAIL rand_wrap[%0d]: got cnt=%0d c=%b e=%b want cnt=%0d c=%b e=%b",
                         i, w_count, w_carry, w_lerr, exp_w_count, exp_w_carry, exp_w_err);
            end else n_pass++;
            n_total++;
            if ({s_count, s_carry, s_lerr, s_term} !==
                {3'(exp_s_count), exp_s_carry, exp_s_err, exp_s_count == 5}) begin
                $display("FAIL rand_stop[%0d]: got cnt=%0d c=%b e=%b want cnt=%0d c=%b e=%b",
                         i, s_count, s_carry, s_lerr, exp_s_count, exp_s_carry, exp_s_err);
            end else n_pass++;
        end
    endtask

`ifdef TIMING_RING_ONEHOT_EN
    task automatic test_onehot();
        n_total++;
        if (t_rerr !== 1'b0) begin
            $display("FAIL ring_err_idle: got %b want 0", t_rerr);
        end else n_pass++;
        cycle(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            n_total++;
            if ({t_count, t_onehot} !== {4'(k), 10'(1) << k}) begin
                $display("FAIL onehot_sweep[%0d]: got cnt=%0d oh=%b", k, t_count, t_onehot);
            end else n_pass++;
            cycle(0, 0, 0, 0, 0, 1);
        end
        force dut_t.u_check.onehot_q = 10'b0000000011;
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        release dut_t.u_check.onehot_q;
        repeat (3) begin
            cycle(0, 1, 0, 0, 0, 0);
            n_total++;
            if (t_rerr !== 1'b1) begin
                $display("FAIL ring_err_sticky: got %b want 1", t_rerr);
            end else n_pass++;
        end
        cycle(1, 0, 0, 0, 0, 0);
        n_total++;
        if ({t_rerr, t_onehot} !== {1'b0, 10'd1}) begin
            $display("FAIL ring_err_rst: got err=%b oh=%b want 0 0000000001", t_rerr,
                     t_onehot);
        end else n_pass++;
    endtask
`endif

    initial begin
        rst    = 1'b1;
        clr    = 1'b0;
        ld     = 1'b0;
        ld_val = 3'd0;
        hold   = 1'b0;
        adv    = 1'b0;
        exp_w_count = 0;
        exp_s_count = 0;
        exp_w_carry = 1'b0;
        exp_w_err   = 1'b0;
        exp_s_carry = 1'b0;
        exp_s_err   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_wrap_run();
        test_strobe();
        test_load();
        test_stop();
        test_priority();
        test_random();
`ifdef TIMING_RING_ONEHOT_EN
        test_onehot();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
